// File: rtl/vec_pkg.sv
// Shared vector-datapath constants, store FSM state type and lane-search helper.
// Used by the vector store unit and the vector register file.
package vec_pkg;

  localparam int unsigned VREG_W     = 128;
  localparam int unsigned LANE_W     = 32;
  localparam int unsigned NUM_LANES  = 4;
  localparam int unsigned VREG_IDX_W = 4;
  localparam int unsigned LANE_IDX_W = 2;
  localparam int unsigned LANE_CNT_W = LANE_IDX_W + 1;

  typedef enum logic [1:0] {
    StIdle,
    StCapture,
    StWrite,
    StDone
  } store_state_e;

  // Lowest enabled lane at or above `from`; returns NUM_LANES when none remain.
  function automatic logic [LANE_CNT_W-1:0] find_lane(input logic [NUM_LANES-1:0] mask,
                                                      input logic [LANE_CNT_W-1:0] from);
    logic [LANE_CNT_W-1:0] res;
    res = LANE_CNT_W'(NUM_LANES);
    for (int i = int'(NUM_LANES) - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(from))) res = LANE_CNT_W'(i);
    end
    return res;
  endfunction

endpackage

// File: rtl/vec_store_unit_if.sv
// Memory write-port bundle: the store unit is the master, data memory the slave.
interface vec_store_unit_if #(
  parameter int unsigned ADDR_W = 32
) ();
  import vec_pkg::*;

  logic                mem_write_en;
  logic [ADDR_W-1:0]   mem_addr;
  logic [LANE_W-1:0]   mem_write_data;
  logic                mem_ready;

  modport master (
    output mem_write_en,
    output mem_addr,
    output mem_write_data,
    input  mem_ready
  );

  modport slave (
    input  mem_write_en,
    input  mem_addr,
    input  mem_write_data,
    output mem_ready
  );

endinterface

// File: rtl/vec_lane_select.sv
// Combinational 128-to-32 lane mux; lane 0 is bits [31:0].
module vec_lane_select
  import vec_pkg::*;
(
  input  logic [VREG_W-1:0]     vreg_i,
  input  logic [LANE_IDX_W-1:0] lane_i,
  output logic [LANE_W-1:0]     lane_o
);

  always_comb begin
    lane_o = vreg_i[31:0];
    unique case (lane_i)
      2'd0: lane_o = vreg_i[31:0];
      2'd1: lane_o = vreg_i[63:32];
      2'd2: lane_o = vreg_i[95:64];
      2'd3: lane_o = vreg_i[127:96];
      default: lane_o = vreg_i[31:0];
    endcase
  end

endmodule

// File: rtl/vec_store_unit.sv
// Vector store unit: snapshots one vector register and writes it out as 32-bit beats.
// Optional macro VEC_STORE_LANE_MASK_EN adds lane_mask_i to skip disabled lanes.
module vec_store_unit
  import vec_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned LANE_STRIDE = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [VREG_IDX_W-1:0] reg_idx_i,
  input  logic [ADDR_W-1:0]     base_addr_i,
`ifdef VEC_STORE_LANE_MASK_EN
  input  logic [NUM_LANES-1:0]  lane_mask_i,
`endif
  output logic                  busy_o,
  output logic                  done_o,
  output logic [VREG_IDX_W-1:0] rf_read_addr_o,
  input  logic [VREG_W-1:0]     rf_read_data_i,
  vec_store_unit_if.master      mem
);

  store_state_e              state_q;
  logic                      busy_q, done_q, wen_q;
  logic [VREG_IDX_W-1:0]     idx_q;
  logic [ADDR_W-1:0]         base_q, addr_q;
  logic [VREG_W-1:0]         buf_q;
  logic [LANE_IDX_W-1:0]     lane_q;
  logic [NUM_LANES-1:0]      mask_val;
  logic [LANE_CNT_W-1:0]     first_lane, next_lane;

`ifdef VEC_STORE_LANE_MASK_EN
  logic [NUM_LANES-1:0] mask_q;
  assign mask_val = mask_q;
`else
  assign mask_val = '1;
`endif

  assign first_lane = find_lane(mask_val, '0);
  assign next_lane  = find_lane(mask_val, {1'b0, lane_q} + LANE_CNT_W'(1));

  function automatic logic [ADDR_W-1:0] lane_addr(input logic [ADDR_W-1:0]     base,
                                                  input logic [LANE_IDX_W-1:0] lane);
    return base + ADDR_W'(lane) * ADDR_W'(LANE_STRIDE);
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wen_q   <= 1'b0;
      idx_q   <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      buf_q   <= '0;
      lane_q  <= '0;
`ifdef VEC_STORE_LANE_MASK_EN
      mask_q  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            idx_q   <= reg_idx_i;
            base_q  <= base_addr_i;
            lane_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= StCapture;
`ifdef VEC_STORE_LANE_MASK_EN
            mask_q  <= lane_mask_i;
`endif
          end
        end
        StCapture: begin
          buf_q <= rf_read_data_i;
          // An all-zero mask finds no lane and skips straight to completion.
          if (first_lane[LANE_IDX_W]) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            lane_q  <= first_lane[LANE_IDX_W-1:0];
            addr_q  <= lane_addr(base_q, first_lane[LANE_IDX_W-1:0]);
            wen_q   <= 1'b1;
            state_q <= StWrite;
          end
        end
        StWrite: begin
          if (mem.mem_ready) begin
            if (next_lane[LANE_IDX_W]) begin
              wen_q   <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              lane_q  <= next_lane[LANE_IDX_W-1:0];
              addr_q  <= lane_addr(base_q, next_lane[LANE_IDX_W-1:0]);
            end
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  vec_lane_select u_lane_select (
    .vreg_i (buf_q),
    .lane_i (lane_q),
    .lane_o (mem.mem_write_data)
  );

  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign rf_read_addr_o   = idx_q;
  assign mem.mem_write_en = wen_q;
  assign mem.mem_addr     = addr_q;

endmodule

// File: tb/tb_vec_store_unit.sv
// Self-checking bench for vec_store_unit: table of directed stores, hand-written corner
// sequences and randomized stores checked against a lane-list reference model.
module tb_vec_store_unit;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [3:0]   reg_idx;
  logic [31:0]  base_addr;
  logic         busy, done;
  logic [3:0]   rf_read_addr;
  logic [127:0] rf_read_data;
  logic [127:0] rf [16];
`ifdef VEC_STORE_LANE_MASK_EN
  logic [3:0]   lane_mask;
`endif

  int errors = 0;
  int checks = 0;

  vec_store_unit_if #(.ADDR_W(32)) mem_if ();

  vec_store_unit #(.ADDR_W(32), .LANE_STRIDE(4)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_i        (start),
    .reg_idx_i      (reg_idx),
    .base_addr_i    (base_addr),
`ifdef VEC_STORE_LANE_MASK_EN
    .lane_mask_i    (lane_mask),
`endif
    .busy_o         (busy),
    .done_o         (done),
    .rf_read_addr_o (rf_read_addr),
    .rf_read_data_i (rf_read_data),
    .mem            (mem_if.master)
  );

  assign rf_read_data = rf[rf_read_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: the store emits one beat per enabled lane, in lane order, from the register
  // contents at command time; latency is capture + beats + stalls + done cycle.
  task automatic run_store(input logic [3:0] idx, input logic [31:0] base,
                           input logic [3:0] mask, input int stall_lane, input int stall_n,
                           input bit rnd_ready, input bit poke, input bit spur,
                           output int lat, output logic [31:0] last_addr);
    logic [31:0]  exp_a[$];
    logic [31:0]  exp_d[$];
    logic [127:0] snap;
    int cyc, beat, stalls_left, stalls, nbeats;
    bit seen_done;
    snap = rf[idx];
    for (int l = 0; l < 4; l++) begin
      if (mask[l]) begin
        exp_a.push_back(base + 32'(l) * 32'd4);
        exp_d.push_back(snap[32*l +: 32]);
      end
    end
    nbeats = exp_a.size();
    @(negedge clk);
    start     = 1'b1;
    reg_idx   = idx;
    base_addr = base;
`ifdef VEC_STORE_LANE_MASK_EN
    lane_mask = mask;
`endif
    mem_if.mem_ready = 1'b0;
    @(posedge clk);
    cyc = 1; beat = 0; stalls_left = stall_n; stalls = 0; seen_done = 0;
    lat = -1; last_addr = '0;
    while (cyc < 200 && !seen_done) begin
      @(negedge clk);
      start   = spur && (cyc == 2);
      reg_idx = spur ? 4'd2 : idx;
      if (cyc == 1) chk("rf_read_addr in capture", rf_read_addr, idx);
      chk("busy during store", busy, 1'b1);
      if (done) begin
        seen_done = 1;
        lat = cyc;
        chk("no beat with done", mem_if.mem_write_en, 1'b0);
        mem_if.mem_ready = 1'b0;
      end else begin
        if (mem_if.mem_write_en) begin
          if (poke && beat == 0) rf[idx] = '1;
          if (exp_a.size() == 0) begin
            chk("unexpected extra beat", 1'b1, 1'b0);
            mem_if.mem_ready = 1'b1;
          end else begin
            chk("beat addr", mem_if.mem_addr, exp_a[0]);
            chk("beat data", mem_if.mem_write_data, exp_d[0]);
            if (beat == stall_lane && stalls_left > 0) begin
              mem_if.mem_ready = 1'b0;
              stalls_left--;
            end else begin
              mem_if.mem_ready = rnd_ready ? ($urandom_range(3) != 0) : 1'b1;
            end
            if (!mem_if.mem_ready) stalls++;
            else begin
              last_addr = mem_if.mem_addr;
              void'(exp_a.pop_front());
              void'(exp_d.pop_front());
              beat++;
            end
          end
        end else begin
          mem_if.mem_ready = 1'($urandom_range(1));
        end
        @(posedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    mem_if.mem_ready = 1'b0;
    chk("done seen within bound", seen_done, 1'b1);
    chk("all beats issued", exp_a.size(), 0);
    if (nbeats > 0) chk("latency", lat, 2 + nbeats + stalls);
    @(posedge clk);
    @(negedge clk);
    chk("done single pulse", done, 1'b0);
    chk("idle after done", busy, 1'b0);
  endtask

  typedef struct {
    logic [3:0]  idx;
    logic [31:0] base;
    int          stall_lane;
    int          stall_n;
    int          exp_lat;
    logic [31:0] exp_last;
  } vec_t;

  vec_t tbl[5];
  int lat;
  logic [31:0] last;

  initial begin
    rst_n = 1'b0; start = 1'b0; reg_idx = '0; base_addr = '0;
    mem_if.mem_ready = 1'b0;
`ifdef VEC_STORE_LANE_MASK_EN
    lane_mask = 4'hF;
`endif
    for (int i = 0; i < 16; i++) rf[i] = {$urandom, $urandom, $urandom, $urandom};
    rf[5] = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;

    tbl[0] = '{4'd5, 32'h0000_0100, -1, 0, 6, 32'h0000_010C};
    tbl[1] = '{4'd5, 32'h0000_0100,  1, 3, 9, 32'h0000_010C};
    tbl[2] = '{4'd7, 32'hFFFF_FFF8, -1, 0, 6, 32'h0000_0004};
    tbl[3] = '{4'd3, 32'h0000_1000,  2, 1, 7, 32'h0000_100C};
    tbl[4] = '{4'd0, 32'hFFFF_FFFC,  0, 2, 8, 32'h0000_0008};

    #12;
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset wen", mem_if.mem_write_en, 1'b0);
    chk("reset addr", mem_if.mem_addr, 32'h0);
    chk("reset data", mem_if.mem_write_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run_store(tbl[i].idx, tbl[i].base, 4'hF, tbl[i].stall_lane, tbl[i].stall_n, 0, 0, 0,
                lat, last);
      chk($sformatf("table[%0d] latency", i), lat, tbl[i].exp_lat);
      chk($sformatf("table[%0d] last addr", i), last, tbl[i].exp_last);
    end

    // Snapshot plus ignored start while busy.
    run_store(4'd5, 32'h0000_0100, 4'hF, -1, 0, 0, 1, 1, lat, last);
    chk("snapshot latency", lat, 6);
    rf[5] = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;

    // Reset asserted mid-store while lane 2 is stalled.
    @(negedge clk);
    start = 1'b1; reg_idx = 4'd6; base_addr = 32'h0000_0300;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; mem_if.mem_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    mem_if.mem_ready = 1'b0;
    chk("lane2 beat pending", mem_if.mem_write_en, 1'b1);
    chk("lane2 addr", mem_if.mem_addr, 32'h0000_0308);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset wen", mem_if.mem_write_en, 1'b0);
    chk("async reset busy", busy, 1'b0);
    chk("async reset done", done, 1'b0);
    chk("async reset addr", mem_if.mem_addr, 32'h0);
    chk("async reset data", mem_if.mem_write_data, 32'h0);
    chk("async reset rf addr", rf_read_addr, 4'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no done after reset", done, 1'b0);
    end
    run_store(4'd6, 32'h0000_0300, 4'hF, -1, 0, 0, 0, 0, lat, last);
    chk("post-reset last addr", last, 32'h0000_030C);

`ifdef VEC_STORE_LANE_MASK_EN
    run_store(4'd5, 32'h0000_0200, 4'b1010, -1, 0, 0, 0, 0, lat, last);
    chk("mask 1010 last addr", last, 32'h0000_020C);
    run_store(4'd5, 32'h0000_0200, 4'b0000, -1, 0, 0, 0, 0, lat, last);
    chk("mask 0000 no beats", last, 32'h0);
`endif

    for (int i = 0; i < 20; i++) begin
      run_store(4'($urandom_range(15)), $urandom, 4'hF, -1, 0, 1, 1'($urandom_range(1)),
                1'($urandom_range(1)), lat, last);
      rf[i % 16] = {$urandom, $urandom, $urandom, $urandom};
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
